// File: rtl/nios_qsys_onchip_ram_pipelined.sv
// Avalon-MM single-port on-chip RAM slave with configurable width, depth and read
// latency, plus a clear engine that fills the array with CLEAR_VALUE after reset.
module nios_qsys_onchip_ram_pipelined #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 15,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] clr_cnt_nxt;
  logic                  clr_we;

  logic                  en;
  logic                  acc;
  logic                  rd_acc;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [BE_WIDTH-1:0]   ram_be;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  rd_v1;

  assign en          = clken & ~reset_req;
  assign waitrequest = ~((state == ST_READY) & en);
  assign acc         = (state == ST_READY) & en & chipselect & ~waitrequest;
  assign rd_acc      = acc & read & ~write;

  // Clear engine: one word per enabled cycle, last word moves the FSM to READY.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    if (en && state == ST_CLEAR) begin
      if (CLEAR_ON_RESET != 0) begin
        clr_we      = 1'b1;
        clr_cnt_nxt = ADDR_WIDTH'(clr_cnt + 1'b1);
        if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
          state_nxt = ST_READY;
        end
      end else begin
        state_nxt = ST_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else if (en) begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      init_done <= (state_nxt == ST_READY);
    end
  end

  // The clear engine and the slave share the single RAM port; they are never active together.
  always_comb begin
    ram_we    = ~reset & (clr_we | (acc & write));
    ram_addr  = clr_we ? clr_cnt     : address;
    ram_wdata = clr_we ? CLEAR_VALUE : writedata;
    ram_be    = clr_we ? {BE_WIDTH{1'b1}} : byteenable;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (ram_be[k]) begin
          mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
      end
    end
  end

  // First read stage: RAM output register, only loaded on an accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_q <= '0;
      rd_v1 <= 1'b0;
    end else if (en) begin
      rd_v1 <= rd_acc;
      if (rd_acc) begin
        ram_q <= mem[address];
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign readdata      = ram_q;
      assign readdatavalid = rd_v1;
    end else begin : g_lat2
      always_ff @(posedge clk) begin
        if (reset) begin
          readdata      <= '0;
          readdatavalid <= 1'b0;
        end else if (en) begin
          readdatavalid <= rd_v1;
          if (rd_v1) begin
            readdata <= ram_q;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_nios_qsys_onchip_ram_pipelined.sv
// Bench: two RAM instances (read latency 1 and 2) driven by the same stimulus and
// compared against an array/queue reference model of the slave's externally visible rules.
module tb_nios_qsys_onchip_ram_pipelined;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] CV    = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          chipselect;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [3:0]    byteenable;
  logic [DW-1:0] writedata;
  logic          clken;
  logic          reset_req;

  logic [DW-1:0] rd1, rd2;
  logic          rdv1, rdv2, wr1, wr2, id1, id2;

  always #5 clk = ~clk;

  nios_qsys_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut_l1 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .read(read),
    .write(write), .byteenable(byteenable), .writedata(writedata), .clken(clken),
    .reset_req(reset_req), .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1),
    .init_done(id1)
  );

  nios_qsys_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut_l2 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address), .read(read),
    .write(write), .byteenable(byteenable), .writedata(writedata), .clken(clken),
    .reset_req(reset_req), .readdata(rd2), .readdatavalid(rdv2), .waitrequest(wr2),
    .init_done(id2)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] mem_m [DEPTH];
  int          clear_left;
  int          enc;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: enc counts enabled edges; a read accepted at count n is due at n+latency.
  task automatic model_step();
    logic en;
    logic ready;
    logic expv;
    logic [31:0] nw;
    en    = clken & ~reset_req;
    ready = (clear_left == 0);
    check("waitreq_l1", 32'(wr1), 32'(!(ready && en)));
    check("waitreq_l2", 32'(wr2), 32'(!(ready && en)));
    check("init_l1", 32'(id1), 32'(ready));
    check("init_l2", 32'(id2), 32'(ready));

    expv = (q1.size() > 0) && (q1[0].due == enc);
    check("rdvalid_l1", 32'(rdv1), 32'(expv));
    if (expv) begin
      check("rddata_l1", rd1, q1[0].data);
      if (en && !reset) void'(q1.pop_front());
    end
    expv = (q2.size() > 0) && (q2[0].due == enc);
    check("rdvalid_l2", 32'(rdv2), 32'(expv));
    if (expv) begin
      check("rddata_l2", rd2, q2[0].data);
      if (en && !reset) void'(q2.pop_front());
    end

    if (reset) begin
      clear_left = DEPTH;
      q1.delete();
      q2.delete();
    end else if (en) begin
      if (clear_left > 0) begin
        mem_m[DEPTH - clear_left] = CV;
        clear_left--;
      end else if (chipselect && write) begin
        nw = mem_m[address];
        for (int k = 0; k < 4; k++)
          if (byteenable[k]) nw[8*k +: 8] = writedata[8*k +: 8];
        mem_m[address] = nw;
      end else if (chipselect && read) begin
        q1.push_back('{data: mem_m[address], due: enc + 1});
        q2.push_back('{data: mem_m[address], due: enc + 2});
      end
      enc++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic rd, input logic wr, input int a,
                       input logic [3:0] be, input logic [31:0] d);
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = AW'(a);
    byteenable = be;
    writedata  = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic access(input logic rd, input logic wr, input int a,
                        input logic [3:0] be, input logic [31:0] d);
    drive(1'b1, rd, wr, a, be, d);
    step();
  endtask

  task automatic wait_clear(input string tag);
    idle(15);
    check({tag, "_pre_l1"}, 32'(id1), 32'd0);
    check({tag, "_pre_l2"}, 32'(id2), 32'd0);
    idle(1);
    check({tag, "_done_l1"}, 32'(id1), 32'd1);
    check({tag, "_done_l2"}, 32'(id2), 32'd1);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    enc        = 0;
    clear_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    reset      = 1'b1;
    clken      = 1'b1;
    reset_req  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    check("rst_rdata_l1", rd1, 32'h0);
    check("rst_rdata_l2", rd2, 32'h0);
    check("rst_waitreq", 32'(wr1), 32'd1);
    step();
    reset = 1'b0;

    // T1: clear takes 16 cycles, then every word reads back as the fill value
    wait_clear("t1_clear");
    for (int a = 0; a < DEPTH; a++) access(1'b1, 1'b0, a, 4'h0, 32'h0);
    idle(3);

    // T2: byte-enable merge
    access(1'b0, 1'b1, 5, 4'hF, 32'h11223344);
    access(1'b0, 1'b1, 5, 4'b0101, 32'hAABBCCDD);
    access(1'b1, 1'b0, 5, 4'h0, 32'h0);
    idle(3);

    // T3: back-to-back reads
    access(1'b0, 1'b1, 1, 4'hF, 32'h0101_0101);
    access(1'b0, 1'b1, 2, 4'hF, 32'h0202_0202);
    access(1'b0, 1'b1, 3, 4'hF, 32'h0303_0303);
    for (int a = 1; a <= 3; a++) access(1'b1, 1'b0, a, 4'h0, 32'h0);
    idle(4);

    // T5: freeze with two reads in flight; held requests during freeze are ignored
    access(1'b1, 1'b0, 2, 4'h0, 32'h0);
    access(1'b1, 1'b0, 5, 4'h0, 32'h0);
    clken = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) step();
    clken = 1'b1;
    idle(4);

    // T6: read and write together write only
    access(1'b1, 1'b1, 7, 4'hF, 32'h5);
    idle(2);
    access(1'b1, 1'b0, 7, 4'h0, 32'h0);
    idle(3);

    // T4: reset at counter 9 restarts the clear
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(9);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    wait_clear("t4_restart");
    for (int a = 0; a < DEPTH; a++) access(1'b1, 1'b0, a, 4'h0, 32'h0);
    idle(3);

    // Random traffic with clock-enable holes and rare resets
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) != 0, $urandom % 2 == 0, $urandom % 3 == 0,
            int'($urandom % DEPTH), 4'($urandom), $urandom);
      clken     = ($urandom % 10) != 0;
      reset_req = ($urandom % 20) == 0;
      reset     = ($urandom % 500) == 0;
      step();
    end
    reset     = 1'b0;
    reset_req = 1'b0;
    clken     = 1'b1;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
